// File: rtl/load_store_ctrl_if.sv
// Execute-stage request, data-memory bus and writeback signals of the load/store controller.
// The slave modport is the controller; master is the surrounding pipeline/memory.
interface load_store_ctrl_if;
    logic        req_valid;
    logic        mem_read_control;
    logic        mem_write_control;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        req_ready;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        resp_valid;
    logic        resp_err;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport slave (
        input  req_valid, mem_read_control, mem_write_control, funct3, addr, wdata, rd,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output req_ready, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output resp_valid, resp_err, wb_valid, wb_rd, wb_data
    );

    modport master (
        output req_valid, mem_read_control, mem_write_control, funct3, addr, wdata, rd,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  req_ready, stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  resp_valid, resp_err, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/load_store_ctrl.sv
// Load/store unit controller: one outstanding data-memory access, byte/half/word formatting.
// Optional macro LSU_TIMEOUT_EN adds a 255-cycle grant/read-data timeout reported as resp_err.
module load_store_ctrl (
    input logic               clk,
    input logic               rst_n,
    load_store_ctrl_if.slave  lsu
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic        is_load_q, err_q;
    logic [31:0] addr_q, wdata_q, load_data_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;

    logic        accept, illegal, misaligned, bad_funct3, tmo_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data, store_data;
    logic [3:0]  store_be;

    assign accept = lsu.req_valid & (state == IDLE) & (lsu.mem_read_control | lsu.mem_write_control);

    always_comb begin
        misaligned = ((lsu.funct3[1:0] == 2'b01) & lsu.addr[0]) |
                     ((lsu.funct3[1:0] == 2'b10) & (lsu.addr[1:0] != 2'b00));
        bad_funct3 = (lsu.funct3[1:0] == 2'b11) |
                     (lsu.mem_read_control & (lsu.funct3 == 3'b110)) |
                     (lsu.mem_write_control & lsu.funct3[2]);
        illegal    = (lsu.mem_read_control & lsu.mem_write_control) | bad_funct3 | misaligned;
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Restarts on every entry into REQ or WAIT so each phase gets its own budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= 8'd0;
        else if ((state_next == REQ || state_next == WAIT) && state_next != state)
            tmo_cnt <= 8'd0;
        else if (state == REQ || state == WAIT)
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign tmo_hit = (tmo_cnt == 8'hFF);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = illegal ? RESP : REQ;
            REQ: begin
                if (lsu.dmem_gnt)  state_next = is_load_q ? WAIT : RESP;
                else if (tmo_hit)  state_next = RESP;
            end
            WAIT: if (lsu.dmem_rvalid || tmo_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load_q   <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            funct3_q    <= 3'd0;
            rd_q        <= 5'd0;
            load_data_q <= 32'd0;
        end else begin
            if (accept) begin
                is_load_q <= lsu.mem_read_control;
                err_q     <= illegal;
                addr_q    <= lsu.addr;
                wdata_q   <= lsu.wdata;
                funct3_q  <= lsu.funct3;
                rd_q      <= lsu.rd;
            end
            if (state == WAIT && lsu.dmem_rvalid)
                load_data_q <= load_data;
            if (((state == REQ && !lsu.dmem_gnt) || (state == WAIT && !lsu.dmem_rvalid)) && tmo_hit)
                err_q <= 1'b1;
        end
    end

    // Lane extraction works on the latched address, which is already known to be aligned.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_sel = lsu.dmem_rdata[7:0];
            2'b01:   byte_sel = lsu.dmem_rdata[15:8];
            2'b10:   byte_sel = lsu.dmem_rdata[23:16];
            default: byte_sel = lsu.dmem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? lsu.dmem_rdata[31:16] : lsu.dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = lsu.dmem_rdata;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                store_be   = 4'b0001 << addr_q[1:0];
                store_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata_q[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = wdata_q;
            end
        endcase
    end

    // Every bus output is gated by state so an async reset clears them without a clock.
    assign lsu.req_ready  = (state == IDLE);
    assign lsu.stall      = rst_n & ((state == REQ) | (state == WAIT) | accept);
    assign lsu.dmem_req   = (state == REQ);
    assign lsu.dmem_we    = (state == REQ) & ~is_load_q;
    assign lsu.dmem_addr  = (state == REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign lsu.dmem_wdata = (state == REQ) ? store_data : 32'd0;
    assign lsu.dmem_be    = (state == REQ) ? store_be : 4'd0;
    assign lsu.resp_valid = (state == RESP);
    assign lsu.resp_err   = (state == RESP) & err_q;
    assign lsu.wb_valid   = (state == RESP) & is_load_q & ~err_q;
    assign lsu.wb_rd      = lsu.wb_valid ? rd_q : 5'd0;
    assign lsu.wb_data    = lsu.wb_valid ? load_data_q : 32'd0;
endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 req_valid  in  1  execute stage presents an instruction this cycle.
REQ-004 mem_read_control  in  1  instruction is a load.
REQ-005 mem_write_control  in  1  instruction is a store.
REQ-006 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  in  32  effective byte address from ALU.
REQ-008 wdata  in  32  store data (rs2).
REQ-009 rd  in  5  load destination register.
REQ-010 req_ready  out  1  high only in IDLE.
REQ-011 stall  out  1  freeze upstream pipeline.
REQ-012 dmem_req, dmem_we  out  1,1  data-memory request / write-enable.
REQ-013 dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 dmem_wdata, dmem_be  out  32,4  lane-replicated store data, byte enables.
REQ-015 dmem_gnt, dmem_rvalid  in  1,1  request accepted / read data valid.
REQ-016 dmem_rdata  in  32  read word.
REQ-017 resp_valid, resp_err  out  1,1  one-cycle completion pulse / error flag.
REQ-018 wb_valid, wb_rd, wb_data  out  1,5,32  load writeback.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, RESP; encoding free.
REQ-020 Accept when req_valid & req_ready & (mem_read_control | mem_write_control); latch addr, wdata, funct3, rd, op type.
REQ-021 Accepted legal op SHALL go IDLE->REQ; dmem_req high from the next cycle, held with stable outputs until dmem_gnt.
REQ-022 Illegal op (misaligned: H with addr[0]=1, W with addr[1:0]!=0; load funct3 011/110/111; store funct3 >=011; read & write both high) SHALL go IDLE->RESP with resp_err=1, no dmem_req ever.
REQ-023 REQ with dmem_gnt: store -> RESP; load -> WAIT.
REQ-024 WAIT with dmem_rvalid -> RESP; dmem_rvalid in any other state SHALL be ignored.
REQ-025 RESP SHALL last exactly one cycle, assert resp_valid, then return to IDLE.
REQ-026 wb_valid = resp_valid & load & ~resp_err; wb_rd/wb_data registered, valid only while wb_valid.
REQ-027 Load data: select lane by addr[1:0] (byte) or addr[1] (half); B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-028 Store: SB be=0001<<addr[1:0], byte replicated x4; SH be=0011<<(2*addr[1]), half replicated x2; SW be=1111.
REQ-029 stall = (state is REQ or WAIT) | (state is IDLE & req_valid & (mem_read_control | mem_write_control)); low in RESP.
REQ-030 Minimum latency: accept cycle N, dmem_req N+1; gnt at N+1 -> store resp_valid N+2; load rvalid N+2 -> wb_valid N+3.
REQ-031 Non-memory req_valid SHALL be ignored, stall low.

Reset
REQ-032 rst_n low SHALL immediately force IDLE and zero every output except req_ready=1, independent of clk.
REQ-033 Reset mid-REQ/WAIT SHALL drop dmem_req same instant; post-reset late dmem_rvalid/dmem_gnt SHALL be ignored.

Configuration
REQ-034 Macro LSU_TIMEOUT_EN defined: 8-bit counter, cleared on entry to REQ and WAIT, increments each cycle there; at count 255 without gnt/rvalid -> RESP with resp_err=1, dmem_req dropped.
REQ-035 LSU_TIMEOUT_EN undefined: no counter; REQ/WAIT wait indefinitely; resp_err only per REQ-022.

Verification
REQ-036 LW addr 0x100, gnt immediate, rvalid next cycle rdata 0xDEADBEEF -> wb_valid N+3, wb_data 0xDEADBEEF, stall high N..N+2.
REQ-037 LB addr 0x103, rdata 0x80112233 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr 0x202 wdata 0x0000ABCD, gnt after 3 cycles -> dmem_be 1100, dmem_wdata 0xABCDABCD, dmem_addr 0x200 stable until gnt, resp_valid next cycle.
REQ-039 LW addr 0x101 -> resp_valid & resp_err at N+1, dmem_req never high, wb_valid 0.
REQ-040 rst_n low during WAIT -> IDLE, dmem_req 0 same instant; later rvalid produces no wb_valid.
REQ-041 With LSU_TIMEOUT_EN, gnt withheld -> resp_err pulse after 255 cycles in REQ; without it, still REQ after 1000 cycles.
